// File: rtl/fetch_stage.sv
// fetch_stage
// -----------
// Instruction fetch stage with a single outstanding instruction-memory read,
// a one-entry output buffer towards decode and a one-entry hold register that
// parks a response arriving while decode is stalled on a valid instruction.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-low reset
//   stall        1 = decode keeps its register this cycle
//   redirect     taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc  12-bit target PC (valid when redirect=1)
//   imem_req     one-cycle read request to instruction memory
//   imem_addr    word address of the request (always shows fetch_pc)
//   imem_valid   one-cycle response strobe from instruction memory
//   imem_rdata   16-bit instruction word (valid when imem_valid=1)
//   pcF          PC of the presented instruction
//   instF        presented instruction, NOP_INST when validF=0
//   validF       pcF/instF hold a real instruction
//   dbg_state    current FSM state (0 ISSUE, 1 WAIT, 2 HOLD, 3 DRAIN)
//
// Handshake towards decode: the buffer {pcF, instF, validF} is taken by
// decode at every rising edge where stall=0. An entry with validF=1 is
// therefore "consumed" when stall=0, and an empty buffer (validF=0) can
// always be overwritten. While validF=1 and stall=1 the buffer is frozen.
// Memory side: imem_req is a single-cycle pulse, memory always accepts it,
// and exactly one imem_valid pulse answers each request, in order.

module fetch_stage #(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [11:0] redirect_pc,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic [11:0] pcF,
    output logic [15:0] instF,
    output logic        validF,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] fetch_pc_q, fetch_pc_d;
    logic [11:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic [15:0] hold_inst_q, hold_inst_d;
    logic        consume;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        hold_inst_d = hold_inst_q;
        consume     = !valid_q || !stall;

        if (redirect) begin
            // Flush beats stall: the presented instruction is on the wrong
            // path. pcF is left alone; only validF/instF are cleared.
            fetch_pc_d = redirect_pc;
            valid_d    = 1'b0;
            inst_d     = NOP_INST;
            case (state_q)
                // A request is (or just was) in flight: wait for and drop
                // its response unless it is arriving right now.
                ST_ISSUE: state_d = ST_DRAIN;
                ST_WAIT:  state_d = imem_valid ? ST_ISSUE : ST_DRAIN;
                ST_HOLD:  state_d = ST_ISSUE;
                ST_DRAIN: state_d = imem_valid ? ST_ISSUE : ST_DRAIN;
                default:  state_d = ST_ISSUE;
            endcase
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    state_d = ST_WAIT;
                    if (consume) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                    end
                end
                ST_WAIT: begin
                    if (imem_valid && consume) begin
                        pc_d       = fetch_pc_q;
                        inst_d     = imem_rdata;
                        valid_d    = 1'b1;
                        fetch_pc_d = fetch_pc_q + 12'd1;
                        state_d    = ST_ISSUE;
                    end else if (imem_valid) begin
                        // Buffer is full and frozen: park the word.
                        hold_inst_d = imem_rdata;
                        state_d     = ST_HOLD;
                    end else if (consume) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                    end
                end
                ST_HOLD: begin
                    // HOLD is only entered with validF=1, so stall=0 means
                    // the buffer is consumed and can take the parked word.
                    if (!stall) begin
                        pc_d       = fetch_pc_q;
                        inst_d     = hold_inst_q;
                        valid_d    = 1'b1;
                        fetch_pc_d = fetch_pc_q + 12'd1;
                        state_d    = ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    if (imem_valid) begin
                        state_d = ST_ISSUE;
                    end
                    if (consume) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                    end
                end
                default: state_d = ST_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_ISSUE;
            fetch_pc_q  <= RESET_PC;
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            valid_q     <= 1'b0;
            hold_inst_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    // Gating with reset keeps the request low while reset is held, even
    // though the state register already sits in ISSUE.
    assign imem_req  = reset && (state_q == ST_ISSUE);
    assign imem_addr = fetch_pc_q;
    assign pcF       = pc_q;
    assign instF     = inst_q;
    assign validF    = valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a responder memory whose word at address a is
// 16'hA000 + a with a programmable latency, directed scenarios with literal
// expectations, a randomised stall/redirect soak, and a cycle-by-cycle
// transaction-level model of the fetch stream.

module tb_fetch_stage;

    localparam logic [11:0] RESET_PC = 12'h000;
    localparam logic [15:0] NOP_INST = 16'h0000;
    localparam logic [1:0]  S_ISSUE  = 2'd0;
    localparam logic [1:0]  S_WAIT   = 2'd1;
    localparam logic [1:0]  S_HOLD   = 2'd2;
    localparam logic [1:0]  S_DRAIN  = 2'd3;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [11:0] pcF;
    logic [15:0] instF;
    logic        validF;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 1;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .pcF         (pcF),
        .instF       (instF),
        .validF      (validF),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [15:0] mem_word(input logic [11:0] a);
        return 16'hA000 + {4'h0, a};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responder ----------------
    // Samples the request mid-cycle, answers after mem_lat cycles; reset
    // drops anything outstanding.
    initial begin
        logic        req_seen;
        logic        rst_seen;
        logic [11:0] req_addr;
        logic [11:0] p_addr;
        int          cnt;
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        cnt        = 0;
        p_addr     = 12'h000;
        forever begin
            @(negedge clk);
            rst_seen = !reset;
            req_seen = reset && imem_req;
            req_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_valid = 1'b0;
            if (rst_seen) begin
                cnt = 0;
            end else begin
                if (req_seen) begin
                    cnt    = mem_lat;
                    p_addr = req_addr;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_valid = 1'b1;
                        imem_rdata = mem_word(p_addr);
                    end
                end
            end
        end
    end

    // ---------------- reference model + compare ----------------
    // exp_q holds the requested addresses that must still reach decode, in
    // order; a redirect or reset empties it. Requests must walk sequentially
    // from the last redirect/reset target.
    logic [11:0] exp_q[$];
    logic [11:0] next_addr   = RESET_PC;
    bit          outstanding = 1'b0;
    bit          chk_rst     = 1'b0;
    bit          chk_redir   = 1'b0;
    bit          chk_stable  = 1'b0;
    logic [11:0] sv_pc;
    logic [15:0] sv_inst;
    logic [11:0] front;

    always @(negedge clk) begin
        if (chk_rst) begin
            chk("rst_pcF", {4'h0, pcF}, {4'h0, RESET_PC});
            chk("rst_validF", {15'h0, validF}, 16'h0);
            chk("rst_instF", instF, NOP_INST);
        end
        if (chk_redir) begin
            chk("redir_validF", {15'h0, validF}, 16'h0);
            chk("redir_instF", instF, NOP_INST);
        end
        if (chk_stable) begin
            chk("stall_pcF", {4'h0, pcF}, {4'h0, sv_pc});
            chk("stall_instF", instF, sv_inst);
            chk("stall_validF", {15'h0, validF}, 16'h1);
        end
        chk_rst    = 1'b0;
        chk_redir  = 1'b0;
        chk_stable = 1'b0;

        if (!reset) begin
            chk("req_in_reset", {15'h0, imem_req}, 16'h0);
            exp_q.delete();
            next_addr   = RESET_PC;
            outstanding = 1'b0;
            chk_rst     = 1'b1;
        end else begin
            if (validF === 1'b0) chk("nop_when_invalid", instF, NOP_INST);
            if (imem_valid) outstanding = 1'b0;
            if (imem_req) begin
                chk("req_addr", {4'h0, imem_addr}, {4'h0, next_addr});
                chk("one_outstanding", {15'h0, outstanding}, 16'h0);
                exp_q.push_back(imem_addr);
                next_addr   = imem_addr + 12'd1;
                outstanding = 1'b1;
            end
            if (redirect) begin
                exp_q.delete();
                next_addr = redirect_pc;
                chk_redir = 1'b1;
            end else if (validF && !stall) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL deliver: actual pc=%h with nothing requested, expected no valid instruction", pcF);
                end else begin
                    front = exp_q.pop_front();
                    chk("deliver_pc", {4'h0, pcF}, {4'h0, front});
                    chk("deliver_inst", instF, mem_word(front));
                end
            end else if (validF && stall) begin
                sv_pc      = pcF;
                sv_inst    = instF;
                chk_stable = 1'b1;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- directed + soak stimulus ----------------
    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 12'h000;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        // C0: first request straight out of reset
        @(negedge clk);
        chk("c0_req", {15'h0, imem_req}, 16'h1);
        chk("c0_addr", {4'h0, imem_addr}, 16'h000);
        chk("c0_validF", {15'h0, validF}, 16'h0);
        chk("c0_instF", instF, 16'h0000);
        chk("c0_pcF", {4'h0, pcF}, 16'h000);

        // Stream at one instruction per two cycles
        cyc();                          // C1
        cyc(); @(negedge clk);          // C2
        chk("c2_pcF", {4'h0, pcF}, 16'h000);
        chk("c2_instF", instF, 16'hA000);
        chk("c2_validF", {15'h0, validF}, 16'h1);
        chk("c2_req_addr", {4'h0, imem_addr}, 16'h001);
        cyc(); @(negedge clk);          // C3
        chk("c3_validF", {15'h0, validF}, 16'h0);
        cyc(); @(negedge clk);          // C4
        chk("c4_pcF", {4'h0, pcF}, 16'h001);
        chk("c4_instF", instF, 16'hA001);
        cyc(); cyc(); @(negedge clk);   // C6
        chk("c6_pcF", {4'h0, pcF}, 16'h002);
        chk("c6_instF", instF, 16'hA002);

        // Response for 005 lands while decode is stalled on 004
        repeat (4) cyc();               // C10
        stall = 1'b1;
        @(negedge clk);
        chk("c10_pcF", {4'h0, pcF}, 16'h004);
        chk("c10_req_addr", {4'h0, imem_addr}, 16'h005);
        cyc();                          // C11
        cyc(); @(negedge clk);          // C12
        chk("c12_state", {14'h0, dbg_state}, {14'h0, S_HOLD});
        chk("c12_req", {15'h0, imem_req}, 16'h0);
        chk("c12_pcF", {4'h0, pcF}, 16'h004);
        cyc(); stall = 1'b0; @(negedge clk); // C13
        chk("c13_state", {14'h0, dbg_state}, {14'h0, S_HOLD});
        cyc(); @(negedge clk);          // C14
        chk("c14_pcF", {4'h0, pcF}, 16'h005);
        chk("c14_instF", instF, 16'hA005);
        chk("c14_req_addr", {4'h0, imem_addr}, 16'h006);

        // Redirect while the 007 read is still in flight -> DRAIN
        cyc(); @(negedge clk);          // C15
        mem_lat = 2;
        cyc(); @(negedge clk);          // C16
        chk("c16_req_addr", {4'h0, imem_addr}, 16'h007);
        cyc(); redirect = 1'b1; redirect_pc = 12'h100; @(negedge clk); // C17
        chk("c17_imem_valid", {15'h0, imem_valid}, 16'h0);
        cyc(); redirect = 1'b0; @(negedge clk); // C18
        chk("c18_state", {14'h0, dbg_state}, {14'h0, S_DRAIN});
        chk("c18_validF", {15'h0, validF}, 16'h0);
        chk("c18_req", {15'h0, imem_req}, 16'h0);
        mem_lat = 1;
        cyc(); @(negedge clk);          // C19
        chk("c19_req", {15'h0, imem_req}, 16'h1);
        chk("c19_req_addr", {4'h0, imem_addr}, 16'h100);

        // Redirect coinciding with the response -> straight to ISSUE
        cyc(); redirect = 1'b1; redirect_pc = 12'h200; @(negedge clk); // C20
        chk("c20_state", {14'h0, dbg_state}, {14'h0, S_WAIT});
        chk("c20_imem_valid", {15'h0, imem_valid}, 16'h1);
        cyc(); redirect = 1'b0; @(negedge clk); // C21
        chk("c21_state", {14'h0, dbg_state}, {14'h0, S_ISSUE});
        chk("c21_req_addr", {4'h0, imem_addr}, 16'h200);
        chk("c21_validF", {15'h0, validF}, 16'h0);

        // Redirect in ISSUE to FFF, then wrap to 000
        cyc(); cyc(); redirect = 1'b1; redirect_pc = 12'hFFF; @(negedge clk); // C23
        chk("c23_pcF", {4'h0, pcF}, 16'h200);
        chk("c23_instF", instF, 16'hA200);
        cyc(); redirect = 1'b0; @(negedge clk); // C24
        chk("c24_state", {14'h0, dbg_state}, {14'h0, S_DRAIN});
        cyc(); @(negedge clk);          // C25
        chk("c25_req_addr", {4'h0, imem_addr}, 16'hFFF);
        cyc(); cyc(); stall = 1'b1; @(negedge clk); // C27
        chk("c27_pcF", {4'h0, pcF}, 16'hFFF);
        chk("c27_instF", instF, 16'hAFFF);
        chk("c27_req_addr", {4'h0, imem_addr}, 16'h000);

        // Reset while holding a parked word
        cyc();                          // C28
        cyc(); reset = 1'b0; @(negedge clk); // C29
        chk("c29_state", {14'h0, dbg_state}, {14'h0, S_HOLD});
        chk("c29_validF", {15'h0, validF}, 16'h1);
        cyc(); @(negedge clk);          // C30
        chk("c30_validF", {15'h0, validF}, 16'h0);
        chk("c30_instF", instF, 16'h0000);
        chk("c30_pcF", {4'h0, pcF}, 16'h000);
        chk("c30_req", {15'h0, imem_req}, 16'h0);
        cyc(); reset = 1'b1; stall = 1'b0; @(negedge clk); // C31
        chk("c31_req", {15'h0, imem_req}, 16'h1);
        chk("c31_req_addr", {4'h0, imem_addr}, 16'h000);

        // Soak: random stalls, redirects and latencies under the model
        for (int i = 0; i < 400; i++) begin
            cyc();
            stall    = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom_range(0, 4095));
            @(negedge clk);
            mem_lat = $urandom_range(1, 3);
        end
        cyc();
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (10) cyc();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
